muldiv_unit: RTL and testbench

//   Iterative RV32M multiply/divide unit: MUL/MULH/MULHSU/MULHU and DIV/DIVU/REM/REMU.

---
 rtl/muldiv_unit.sv | 250 +++++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide unit placed beside the integer ALU.
//   Supports MUL/MULH/MULHSU/MULHU (op[2]=0) and DIV/DIVU/REM/REMU (op[2]=1).
//
// Ports
//   clk              in   1   rising-edge clock
//   reset            in   1   synchronous, active-high reset
//   valid            in   1   start strobe, sampled only while idle (busy=0)
//   op               in   3   op[2]: 0 mul / 1 div, op[1:0]: sub-op
//   in1              in   32  factor1 / dividend
//   in2              in   32  factor2 / divisor
//   result           out  32  product, quotient or remainder; valid while ready=1
//   ready            out  1   one-cycle completion pulse
//   busy             out  1   operation in progress
//   div_by_zero_err  out  1   last completed div op had a zero divisor
//
// Handshake: the ALU raises valid while busy=0; the unit latches op/in1/in2
//   on that edge (E0) and raises busy. Exactly one ready pulse follows; result
//   and div_by_zero_err are stable during it and hold until the next op
//   finishes. busy stays high through the ready cycle and drops on the next
//   cycle, so a valid during the ready cycle is ignored. valid while busy is
//   ignored (no queuing). reset aborts an op without a ready pulse.
//
// Latency: ready is high in the cycle after edge E0+34.
//
// Configuration macro: MULDIV_FAST_MUL_EN
//   defined   : mul ops use a single registered signed multiply of the
//               sign/zero-extended operands, ready in the cycle after E0+2.
//   undefined : every op uses the 32-step iterative datapath.
//   Results are identical in both builds.
// -----------------------------------------------------------------------------
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [2:0]  op,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic [31:0] result,
    output logic        ready,
    output logic        busy,
    output logic        div_by_zero_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] op_a_q, op_a_d;      // original in1 (div-by-zero remainder)
    logic [31:0] b_abs_q, b_abs_d;    // |multiplicand| or |divisor|
    logic [63:0] acc_q, acc_d;        // {hi/rem, lo/quot}
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;        // product / quotient must be negated
    logic        rem_neg_q, rem_neg_d;
    logic        div_zero_q, div_zero_d;
    logic [31:0] result_q, result_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;

    // Signedness per sub-op. MULHSU is signed in1, unsigned in2.
    function automatic logic in1_is_signed(input logic [2:0] o);
        in1_is_signed = o[2] ? ~o[0] : (o[1:0] != 2'b11);
    endfunction

    function automatic logic in2_is_signed(input logic [2:0] o);
        in2_is_signed = o[2] ? ~o[0] : ~o[1];
    endfunction

    // Operand conditioning at start.
    logic        a_neg, b_neg;
    logic [31:0] a_abs, b_abs;

    assign a_neg = in1_is_signed(op) & in1[31];
    assign b_neg = in2_is_signed(op) & in2[31];
    assign a_abs = a_neg ? (~in1 + 32'd1) : in1;
    assign b_abs = b_neg ? (~in2 + 32'd1) : in2;

    // One shift-add multiply step: add the multiplicand into the high half
    // when the current multiplier bit is set, then shift right with carry.
    logic [32:0] mul_sum;
    assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_abs_q} : 33'd0);

    // One restoring divide step: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits. The partial remainder
    // is always below the divisor, so the difference fits in 32 bits.
    logic [32:0] rem_sh;
    logic        div_ge;
    logic [31:0] div_diff;

    assign rem_sh   = acc_q[63:31];
    assign div_ge   = (rem_sh >= {1'b0, b_abs_q});
    assign div_diff = rem_sh[31:0] - b_abs_q;

    // Full 64-bit signed-corrected product.
    logic [63:0] mul_full;
`ifdef MULDIV_FAST_MUL_EN
    logic [31:0] op_b_q, op_b_d;
    logic [63:0] fast_a, fast_b;

    // Extending both operands to 64 bits by their own signedness makes the
    // truncated 64-bit product equal the exact 33x33 signed product.
    assign fast_a   = {{32{in1_is_signed(op_q) & op_a_q[31]}}, op_a_q};
    assign fast_b   = {{32{in2_is_signed(op_q) & op_b_q[31]}}, op_b_q};
    assign mul_full = fast_a * fast_b;
`else
    assign mul_full = neg_q ? (~acc_q + 64'd1) : acc_q;
`endif

    // Quotient/remainder correction. Divide by zero is forced to the RISC-V
    // values; signed overflow falls out naturally (|0x8000_0000| / 1).
    logic [31:0] quot_fix, rem_fix, fix_result;

    assign quot_fix = div_zero_q ? 32'hFFFF_FFFF
                                 : (neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0]);
    assign rem_fix  = div_zero_q ? op_a_q
                                 : (rem_neg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32]);

    always_comb begin
        fix_result = 32'd0;
        if (op_q[2]) begin
            fix_result = op_q[1] ? rem_fix : quot_fix;
        end else begin
            fix_result = (op_q[1:0] == 2'b00) ? mul_full[31:0] : mul_full[63:32];
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        op_a_d     = op_a_q;
        b_abs_d    = b_abs_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        result_d   = result_q;
        ready_d    = 1'b0;
        busy_d     = busy_q;
        err_d      = err_q;
`ifdef MULDIV_FAST_MUL_EN
        op_b_d     = op_b_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // busy_q still set here means this is the ready cycle.
                if (!busy_q && valid) begin
                    op_d       = op;
                    op_a_d     = in1;
                    b_abs_d    = b_abs;
                    acc_d      = {32'd0, a_abs};
                    cnt_d      = 5'd0;
                    neg_d      = a_neg ^ b_neg;
                    rem_neg_d  = a_neg;
                    div_zero_d = (in2 == 32'd0);
                    busy_d     = 1'b1;
                    state_d    = ST_CALC;
`ifdef MULDIV_FAST_MUL_EN
                    op_b_d     = in2;
                    if (!op[2]) begin
                        state_d = ST_FIX;
                    end
`endif
                end else begin
                    busy_d = 1'b0;
                end
            end

            ST_CALC: begin
                if (op_q[2]) begin
                    acc_d = div_ge ? {div_diff, acc_q[30:0], 1'b1}
                                   : {rem_sh[31:0], acc_q[30:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_FIX;
                end
            end

            ST_FIX: begin
                result_d = fix_result;
                err_d    = op_q[2] & div_zero_q;
                state_d  = ST_DONE;
            end

            ST_DONE: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= 3'd0;
            op_a_q     <= 32'd0;
            b_abs_q    <= 32'd0;
            acc_q      <= 64'd0;
            cnt_q      <= 5'd0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            result_q   <= 32'd0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
            op_b_q     <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            op_a_q     <= op_a_d;
            b_abs_q    <= b_abs_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
`ifdef MULDIV_FAST_MUL_EN
            op_b_q     <= op_b_d;
`endif
        end
    end

    assign result          = result_q;
    assign ready           = ready_q;
    assign busy            = busy_q;
    assign div_by_zero_err = err_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [2:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] result;
    logic        ready;
    logic        busy;
    logic        div_by_zero_err;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;
    localparam int TIMEOUT = 200;
    localparam int NVEC    = 18;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_err;
    } vec_t;

    vec_t vecs[NVEC];

    // ---------------- clock / DUT ----------------
    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk             (clk),
        .reset           (reset),
        .valid           (valid),
        .op              (op),
        .in1             (in1),
        .in2             (in2),
        .result          (result),
        .ready           (ready),
        .busy            (busy),
        .div_by_zero_err (div_by_zero_err)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Issues one op, scrambles the inputs after the accept edge, measures the
    // number of edges from acceptance to ready, and checks the pulse shape.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic err, output int lat);
        @(negedge clk);
        valid = 1'b1;
        op    = o;
        in1   = a;
        in2   = b;
        @(posedge clk);
        #1;
        valid = 1'b0;
        op    = 3'($urandom);
        in1   = $urandom;
        in2   = $urandom;
        lat   = 0;
        check("stale_ready", {31'd0, ready}, 32'd0);
        while (ready !== 1'b1 && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = result;
        err = div_by_zero_err;
        @(posedge clk);
        #1;
        check("pulse_end_ready_busy", {30'd0, ready, busy}, 32'd0);
    endtask

    task automatic expect_no_ready(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (ready !== 1'b0) seen = 1'b1;
        end
        check(name, {31'd0, seen}, 32'd0);
    endtask

    // ---------------- test ----------------
    initial begin
        logic [31:0] res;
        logic        err;
        int          lat;

        reset = 1'b1;
        valid = 1'b0;
        op    = 3'd0;
        in1   = 32'd0;
        in2   = 32'd0;

        vecs[0]  = '{3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
        vecs[1]  = '{3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[2]  = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0};
        vecs[3]  = '{3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0};
        vecs[6]  = '{3'b101, 32'hFFFF_FFFE, 32'd2,         32'h7FFF_FFFF, 1'b0};
        vecs[7]  = '{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1};
        vecs[8]  = '{3'b111, 32'd5,         32'd0,         32'd5,         1'b1};
        vecs[9]  = '{3'b000, 32'd3,         32'd4,         32'd12,        1'b0};
        vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0};
        vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0};
        vecs[12] = '{3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1'b1};
        vecs[13] = '{3'b001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 1'b0};
        vecs[14] = '{3'b111, 32'd100,       32'd7,         32'd2,         1'b0};
        vecs[15] = '{3'b100, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0};
        vecs[16] = '{3'b110, 32'd100,       32'hFFFF_FFF9, 32'd2,         1'b0};
        vecs[17] = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_result", result, 32'd0);
        check("rst_flags", {29'd0, ready, busy, div_by_zero_err}, 32'd0);

        // Directed vector table
        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, err, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
            check($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_latency", i), 32'(lat),
                  32'(vecs[i].op[2] ? DIV_LAT : MUL_LAT));
        end

        // valid while busy is ignored: DIV 20/3 with a MUL strobe mid-op
        @(negedge clk);
        valid = 1'b1;
        op    = 3'b100;
        in1   = 32'd20;
        in2   = 32'd3;
        @(posedge clk);
        #1;
        lat = 0;
        while (ready !== 1'b1 && lat < TIMEOUT) begin
            if (lat == 5) begin
                check("busy_mid_op", {31'd0, busy}, 32'd1);
                valid = 1'b1;
                op    = 3'b000;
                in1   = 32'd2;
                in2   = 32'd2;
            end else begin
                valid = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        valid = 1'b0;
        check("busy_ignore_latency", 32'(lat), 32'(DIV_LAT));
        check("busy_ignore_result", result, 32'd6);
        expect_no_ready("busy_ignore_no_second_ready", 40);

        // Reset mid-op: set err=1 and a nonzero result first
        run_op(3'b100, 32'd5, 32'd0, res, err, lat);
        check("pre_reset_err", {31'd0, err}, 32'd1);
        @(negedge clk);
        valid = 1'b1;
        op    = 3'b100;
        in1   = 32'd100;
        in2   = 32'd7;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midop_reset_result", result, 32'd0);
        check("midop_reset_flags", {29'd0, ready, busy, div_by_zero_err}, 32'd0);
        expect_no_ready("midop_reset_no_ready", 40);

        run_op(3'b111, 32'd100, 32'd7, res, err, lat);
        check("post_reset_result", res, 32'd2);
        check("post_reset_err", {31'd0, err}, 32'd0);
        check("post_reset_latency", 32'(lat), 32'(DIV_LAT));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
